// File: rtl/par_rate_source.sv
// par_rate_source -- parameterised rate-limited item source.
//
// Presents a stream of {payload, dest_addr} items on a valid/busy handshake.
// An item is accepted on any posedge where valid=1 and channel_busy=0. The
// payload is a wrapping sequence number; sent_count is a saturating count of
// accepted items. After each accept the source either presents the next item
// immediately (gap=0) or idles for exactly gap cycles. With count!=0 the
// source stops in a terminal DONE state after count items.
//
// Parameters:
//   id     source identifier, also seeds the destination LFSR
//   dest   fixed destination address (ignored when random dest is enabled)
//   gap    idle cycles between accepted items (0..255)
//   count  items to send before stopping; 0 = unlimited (count <= 65535)
//
// Ports:
//   clk           clock, all state updates on posedge
//   reset         asynchronous, active-high reset
//   enable        start/continue generation
//   channel_busy  downstream busy; blocks acceptance while high
//   valid         item_out holds a pending item
//   item_out      {payload[`PAYLOAD_SIZE], dest_addr[`ADDR_BITS]}
//   done          count items delivered (terminal until reset)
//   sent_count    accepted items so far, saturating at 16'hFFFF
//
// Build option:
//   RATE_SOURCE_RAND_DEST_EN  when defined, dest_addr comes from the low
//   `ADDR_BITS bits of a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1)
//   seeded with {8'hA5, id[7:0]} and advanced once per accepted item.

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module par_rate_source #(
  parameter int                    id    = -1,
  parameter logic [`ADDR_BITS-1:0] dest  = '0,
  parameter int unsigned           gap   = 0,
  parameter int unsigned           count = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                channel_busy,
  output logic                                valid,
  output logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0] item_out,
  output logic                                done,
  output logic [15:0]                         sent_count
);

  localparam logic [7:0]  GAP_LOAD  = 8'(gap);
  localparam logic [16:0] COUNT_CMP = 17'(count);
  localparam bit          COUNT_EN  = (count != 0);
  localparam bit          GAP_EN    = (gap != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [`PAYLOAD_SIZE-1:0]   seq_q, seq_d;
  logic [15:0]                sent_q, sent_d;
  logic [7:0]                 gap_cnt_q, gap_cnt_d;
  logic [`ADDR_BITS-1:0]      dest_addr;
  logic                       transfer;
  logic                       last_item;
  logic [16:0]                sent_plus1;

  assign transfer   = (state_q == SEND) && !channel_busy;
  // Unsaturated compare: sent_count cannot saturate before reaching count.
  assign sent_plus1 = {1'b0, sent_q} + 17'd1;
  assign last_item  = COUNT_EN && (sent_plus1 == COUNT_CMP);

`ifdef RATE_SOURCE_RAND_DEST_EN
  localparam logic [7:0]  ID_LO    = 8'(id);
  localparam logic [15:0] SEED_RAW = {8'hA5, ID_LO};
  localparam logic [15:0] SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (transfer) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dest_addr = lfsr_q[`ADDR_BITS-1:0];
`else
  assign dest_addr = dest;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (transfer) begin
          if (last_item) begin
            state_d = DONE;
          end else if (GAP_EN) begin
            state_d = GAP;
          end else begin
            state_d = SEND;
          end
        end
      end
      GAP: begin
        // Counter value 1 is the last idle cycle.
        if (gap_cnt_q <= 8'd1) begin
          state_d = enable ? SEND : IDLE;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: sequence, saturating count, gap counter.
  always_comb begin
    seq_d     = seq_q;
    sent_d    = sent_q;
    gap_cnt_d = gap_cnt_q;
    if (transfer) begin
      seq_d = seq_q + 1'b1;
      if (sent_q != 16'hFFFF) begin
        sent_d = sent_q + 16'd1;
      end
      if (!last_item && GAP_EN) begin
        gap_cnt_d = GAP_LOAD;
      end
    end else if (state_q == GAP && gap_cnt_q != 8'd0) begin
      gap_cnt_d = gap_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q     <= '0;
      sent_q    <= '0;
      gap_cnt_q <= '0;
    end else begin
      seq_q     <= seq_d;
      sent_q    <= sent_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Output logic.
  always_comb begin
    valid      = (state_q == SEND);
    done       = (state_q == DONE);
    sent_count = sent_q;
    item_out   = '0;
    if (state_q == SEND) begin
      item_out = {seq_q, dest_addr};
    end
  end

endmodule

// File: tb/tb_par_rate_source.sv
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module tb_par_rate_source;

  localparam int PW = `PAYLOAD_SIZE;
  localparam int AW = `ADDR_BITS;
  localparam int IW = PW + AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic en0 = 0, busy0 = 0, en1 = 0, busy1 = 0, en2 = 0, busy2 = 0;
  logic          valid0, valid1, valid2;
  logic          done0, done1, done2;
  logic [IW-1:0] item0, item1, item2;
  logic [15:0]   sent0, sent1, sent2;

  int checks = 0;
  int errors = 0;

  par_rate_source #(.id(-1), .dest(AW'(3)), .gap(0), .count(4)) u0 (
    .clk(clk), .reset(reset), .enable(en0), .channel_busy(busy0),
    .valid(valid0), .item_out(item0), .done(done0), .sent_count(sent0));

  par_rate_source #(.id(-1), .dest(AW'(5)), .gap(2), .count(3)) u1 (
    .clk(clk), .reset(reset), .enable(en1), .channel_busy(busy1),
    .valid(valid1), .item_out(item1), .done(done1), .sent_count(sent1));

  par_rate_source #(.id(1), .dest(AW'(9)), .gap(0), .count(0)) u2 (
    .clk(clk), .reset(reset), .enable(en2), .channel_busy(busy2),
    .valid(valid2), .item_out(item2), .done(done2), .sent_count(sent2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  typedef struct {
    logic          en;
    logic          busy;
    logic          exp_valid;
    logic [PW-1:0] exp_pay;
    logic          exp_done;
    logic [15:0]   exp_sent;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [15:0]   model_lfsr;
    logic [AW-1:0] exp_dest;
    logic [PW-1:0] pay;
    int vpat[8];

    // gap=0,count=4 with sink busy for one cycle after each accept
    vt[0]  = '{1'b0, 1'b0, 1'b0, PW'(0), 1'b0, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, PW'(0), 1'b0, 16'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, PW'(1), 1'b0, 16'd1};
    vt[3]  = '{1'b1, 1'b1, 1'b1, PW'(1), 1'b0, 16'd1};
    vt[4]  = '{1'b1, 1'b0, 1'b1, PW'(2), 1'b0, 16'd2};
    vt[5]  = '{1'b1, 1'b1, 1'b1, PW'(2), 1'b0, 16'd2};
    vt[6]  = '{1'b1, 1'b0, 1'b1, PW'(3), 1'b0, 16'd3};
    vt[7]  = '{1'b1, 1'b1, 1'b1, PW'(3), 1'b0, 16'd3};
    vt[8]  = '{1'b1, 1'b0, 1'b0, PW'(0), 1'b1, 16'd4};
    vt[9]  = '{1'b1, 1'b0, 1'b0, PW'(0), 1'b1, 16'd4};
    vt[10] = '{1'b0, 1'b1, 1'b0, PW'(0), 1'b1, 16'd4};

    vpat = '{1, 0, 0, 1, 0, 0, 1, 0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid0), 0);
    chk("rst_item", 32'(item0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_sent", 32'(sent0), 0);
    reset = 1'b0;

    // table-driven run on u0
    foreach (vt[i]) begin
      en0 = vt[i].en;
      busy0 = vt[i].busy;
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_valid", i), 32'(valid0), 32'(vt[i].exp_valid));
      chk($sformatf("t%0d_done", i), 32'(done0), 32'(vt[i].exp_done));
      chk($sformatf("t%0d_sent", i), 32'(sent0), 32'(vt[i].exp_sent));
      if (vt[i].exp_valid) begin
        chk($sformatf("t%0d_pay", i), 32'(item0[IW-1 -: PW]), 32'(vt[i].exp_pay));
`ifndef RATE_SOURCE_RAND_DEST_EN
        chk($sformatf("t%0d_dest", i), 32'(item0[AW-1:0]), 3);
`endif
      end else begin
        chk($sformatf("t%0d_item0", i), 32'(item0), 0);
      end
    end

    // gap=2,count=3: valid pattern 1,0,0,1,0,0,1,0 then done
    en1 = 1'b1;
    busy1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("gap_valid%0d", i), 32'(valid1), 32'(vpat[i]));
      if (i == 3) chk("gap_pay1", 32'(item1[IW-1 -: PW]), 1);
    end
    chk("gap_done", 32'(done1), 1);
    chk("gap_sent", 32'(sent1), 3);
    busy1 = 1'b1;
    @(posedge clk);
    #1;
    chk("gap_done_hold", 32'(done1), 1);
    en1 = 1'b0;

    // u2: busy held 10 cycles while valid
    model_lfsr = {8'hA5, 8'h01};
    en2 = 1'b1;
    busy2 = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_valid0", 32'(valid2), 1);
    busy2 = 1'b1;
`ifdef RATE_SOURCE_RAND_DEST_EN
    exp_dest = model_lfsr[AW-1:0];
`else
    exp_dest = AW'(9);
`endif
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_item%0d", i), 32'(item2), 32'({PW'(0), exp_dest}));
      chk($sformatf("hold_sent%0d", i), 32'(sent2), 0);
    end
    busy2 = 1'b0;

    // 300 transfers with payload wrap and dest tracking
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      model_lfsr = lfsr_next(model_lfsr);
`ifdef RATE_SOURCE_RAND_DEST_EN
      exp_dest = model_lfsr[AW-1:0];
`endif
      pay = PW'(k);
      chk($sformatf("wrap_pay%0d", k), 32'(item2[IW-1 -: PW]), 32'(pay));
      chk($sformatf("wrap_sent%0d", k), 32'(sent2), 32'(k));
      if (k <= 20 || k > 295)
        chk($sformatf("wrap_dest%0d", k), 32'(item2[AW-1:0]), 32'(exp_dest));
    end
    chk("wrap_done", 32'(done2), 0);
    chk("wrap_valid", 32'(valid2), 1);

    // asynchronous reset mid-SEND with busy high
    busy2 = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(valid2), 0);
    chk("arst_item", 32'(item2), 0);
    chk("arst_sent", 32'(sent2), 0);
    chk("arst_done0", 32'(done0), 0);
    @(posedge clk);
    #1;
    chk("arst_valid_hold", 32'(valid2), 0);
    reset = 1'b0;
    busy2 = 1'b0;
    model_lfsr = {8'hA5, 8'h01};
    @(posedge clk);
    #1;
    chk("post_valid", 32'(valid2), 1);
    chk("post_pay", 32'(item2[IW-1 -: PW]), 0);
    chk("post_sent", 32'(sent2), 0);
`ifdef RATE_SOURCE_RAND_DEST_EN
    chk("post_dest", 32'(item2[AW-1:0]), 32'(model_lfsr[AW-1:0]));
`else
    chk("post_dest", 32'(item2[AW-1:0]), 9);
`endif
    @(posedge clk);
    #1;
    chk("post_pay1", 32'(item2[IW-1 -: PW]), 1);
    chk("post_sent1", 32'(sent2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
